// File: rtl/ibex_trace_pkg.sv
// Record type, header bit layout and beat-count helper for the RVFI trace buffer.
// Memory beats exist only when IBEX_TRACE_MEM_EN is defined.
package ibex_trace_pkg;

  localparam int unsigned TraceMaxBeats = 6;

  localparam int unsigned HdrBeatsLsb = 29;
  localparam int unsigned HdrTrapBit  = 28;
  localparam int unsigned HdrIntrBit  = 27;
  localparam int unsigned HdrModeLsb  = 25;
  localparam int unsigned HdrRdLsb    = 20;
  localparam int unsigned HdrHaltBit  = 19;
  localparam int unsigned HdrOvfBit   = 18;
  localparam int unsigned HdrWmaskLsb = 14;
  localparam int unsigned HdrRmaskLsb = 10;
  localparam int unsigned HdrOrderLsb = 0;

  typedef struct packed {
    logic [9:0]  order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        ovf;
`ifdef IBEX_TRACE_MEM_EN
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
`endif
  } trace_rec_t;

  function automatic logic [2:0] trace_beats(input trace_rec_t rec);
    logic [2:0] n;
    n = 3'd3;
    if (rec.rd_addr != '0) n = n + 3'd1;
`ifdef IBEX_TRACE_MEM_EN
    if ((rec.rmask | rec.wmask) != '0) n = n + 3'd2;
`endif
    return n;
  endfunction

endpackage

// File: rtl/ibex_trace_serializer.sv
// Packet serialiser: walks the FIFO head record beat by beat over a valid/ready stream.
// Memory beats are emitted only when IBEX_TRACE_MEM_EN is defined.
module ibex_trace_serializer
  import ibex_trace_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_avail,
  input  logic        i_more,
  input  trace_rec_t  i_rec,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_pop
);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_beat, w_beat_nxt;
  logic [2:0]  w_nbeats;
  logic        w_has_rd;
  logic        w_hs;
  logic [31:0] w_hdr;
  logic [31:0] w_beat_data;
`ifdef IBEX_TRACE_MEM_EN
  logic [2:0]  w_mem_idx;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_nbeats = trace_beats(i_rec);
    w_has_rd = (i_rec.rd_addr != '0);
    // Header is offered straight from IDLE so a fresh record costs no extra cycle.
    o_valid  = (r_state == S_SEND) || i_avail;
    w_hs     = o_valid && i_ready;
    o_last   = o_valid && (r_beat == (w_nbeats - 3'd1));
    o_pop    = w_hs && o_last;

    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_nxt = S_SEND;
          w_beat_nxt  = r_beat + 3'd1;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (o_last) begin
            w_beat_nxt  = '0;
            w_state_nxt = i_more ? S_SEND : S_IDLE;
          end else begin
            w_beat_nxt  = r_beat + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_hdr = '0;
    w_hdr[HdrBeatsLsb +: 3] = w_nbeats - 3'd1;
    w_hdr[HdrTrapBit]       = i_rec.trap;
    w_hdr[HdrIntrBit]       = i_rec.intr;
    w_hdr[HdrModeLsb +: 2]  = i_rec.mode;
    w_hdr[HdrRdLsb +: 5]    = i_rec.rd_addr;
    w_hdr[HdrHaltBit]       = i_rec.halt;
    w_hdr[HdrOvfBit]        = i_rec.ovf;
    w_hdr[HdrWmaskLsb +: 4] = i_rec.wmask;
    w_hdr[HdrRmaskLsb +: 4] = i_rec.rmask;
    w_hdr[HdrOrderLsb +: 10] = i_rec.order;

    w_beat_data = '0;
`ifdef IBEX_TRACE_MEM_EN
    w_mem_idx = r_beat - 3'd3 - {2'b00, w_has_rd};
`endif
    case (r_beat)
      3'd0: w_beat_data = w_hdr;
      3'd1: w_beat_data = i_rec.pc;
      3'd2: w_beat_data = i_rec.insn;
      default: begin
        if (w_has_rd && (r_beat == 3'd3)) begin
          w_beat_data = i_rec.rd_wdata;
        end
`ifdef IBEX_TRACE_MEM_EN
        else if (w_mem_idx == 3'd0) begin
          w_beat_data = i_rec.mem_addr;
        end else if (w_mem_idx == 3'd1) begin
          w_beat_data = (i_rec.wmask != '0) ? i_rec.mem_wdata : i_rec.mem_rdata;
        end
`endif
      end
    endcase

    o_data = o_valid ? w_beat_data : '0;
  end

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI trace buffer top: record FIFO, overflow flag and saturating drop counter.
// Define IBEX_TRACE_MEM_EN to store memory fields and emit memory beats.
module ibex_rvfi_trace_buffer
  import ibex_trace_pkg::*;
#(
  parameter int unsigned Depth        = 8,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    trace_en_i,
  input  logic                    rvfi_valid,
  input  logic [63:0]             rvfi_order,
  input  logic [31:0]             rvfi_insn,
  input  logic [31:0]             rvfi_pc_rdata,
  input  logic [31:0]             rvfi_rd_wdata,
  input  logic                    rvfi_trap,
  input  logic                    rvfi_halt,
  input  logic                    rvfi_intr,
  input  logic [1:0]              rvfi_mode,
  input  logic [4:0]              rvfi_rd_addr,
  input  logic [31:0]             rvfi_mem_addr,
  input  logic [31:0]             rvfi_mem_rdata,
  input  logic [31:0]             rvfi_mem_wdata,
  input  logic [3:0]              rvfi_mem_rmask,
  input  logic [3:0]              rvfi_mem_wmask,
  output logic                    trace_valid_o,
  input  logic                    trace_ready_i,
  output logic [31:0]             trace_data_o,
  output logic                    trace_last_o,
  output logic [DropCntWidth-1:0] drop_cnt_o,
  output logic [$clog2(Depth):0]  fifo_level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] LevelFull = (PtrW+1)'(Depth);
  localparam logic [PtrW:0] LevelOne  = (PtrW+1)'(1);

  trace_rec_t              r_mem [Depth];
  logic [PtrW-1:0]         r_wptr, r_rptr;
  logic [PtrW:0]           r_level;
  logic                    r_ovf;
  logic [DropCntWidth-1:0] r_drop_cnt;

  logic       w_try, w_full, w_push, w_pop;
  trace_rec_t w_rec;
  logic       w_unused;

  assign w_try  = trace_en_i && rvfi_valid;
  // Fullness is judged on the registered level, so a same-cycle pop never rescues a push.
  assign w_full = (r_level == LevelFull);
  assign w_push = w_try && !w_full;

  always_comb begin
    w_rec          = '0;
    w_rec.order    = rvfi_order[9:0];
    w_rec.insn     = rvfi_insn;
    w_rec.pc       = rvfi_pc_rdata;
    w_rec.rd_wdata = rvfi_rd_wdata;
    w_rec.trap     = rvfi_trap;
    w_rec.halt     = rvfi_halt;
    w_rec.intr     = rvfi_intr;
    w_rec.mode     = rvfi_mode;
    w_rec.rd_addr  = rvfi_rd_addr;
    w_rec.rmask    = rvfi_mem_rmask;
    w_rec.wmask    = rvfi_mem_wmask;
    w_rec.ovf      = r_ovf;
`ifdef IBEX_TRACE_MEM_EN
    w_rec.mem_addr  = rvfi_mem_addr;
    w_rec.mem_rdata = rvfi_mem_rdata;
    w_rec.mem_wdata = rvfi_mem_wdata;
`endif
  end

`ifdef IBEX_TRACE_MEM_EN
  assign w_unused = ^rvfi_order[63:10];
`else
  assign w_unused = ^{rvfi_order[63:10], rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_try && w_full) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end else if (w_push) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  ibex_trace_serializer u_ser (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_avail (r_level != '0),
    .i_more  (r_level > LevelOne),
    .i_rec   (r_mem[r_rptr]),
    .i_ready (trace_ready_i),
    .o_valid (trace_valid_o),
    .o_data  (trace_data_o),
    .o_last  (trace_last_o),
    .o_pop   (w_pop)
  );

  assign drop_cnt_o   = r_drop_cnt;
  assign fifo_level_o = r_level;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Bench for ibex_rvfi_trace_buffer: directed scenarios plus random traffic against a
// queue-of-beats reference model. Honours IBEX_TRACE_MEM_EN like the design.
module tb_ibex_rvfi_trace_buffer;

  localparam int unsigned Depth        = 8;
  localparam int unsigned DropCntWidth = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        trace_en_i, rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_rd_wdata;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic        trace_valid_o, trace_ready_i, trace_last_o;
  logic [31:0] trace_data_o;
  logic [DropCntWidth-1:0] drop_cnt_o;
  logic [$clog2(Depth):0]  fifo_level_o;

  always #5 clk = ~clk;

  ibex_rvfi_trace_buffer #(.Depth(Depth), .DropCntWidth(DropCntWidth)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .trace_en_i(trace_en_i), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o),
    .trace_last_o(trace_last_o), .drop_cnt_o(drop_cnt_o), .fifo_level_o(fifo_level_o)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: every queued beat as {last, data}; level counts unpopped records.
  logic [32:0] m_beats[$];
  int unsigned m_level = 0;
  int unsigned m_drop  = 0;
  bit          m_ovf   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push();
    logic [31:0] b[$];
    logic [31:0] hdr;
    int unsigned nb;
    bit          mem;
    mem = 1'b0;
`ifdef IBEX_TRACE_MEM_EN
    mem = ((rvfi_mem_rmask | rvfi_mem_wmask) != 4'h0);
`endif
    nb  = 3 + ((rvfi_rd_addr != 5'd0) ? 1 : 0) + (mem ? 2 : 0);
    hdr = ((nb - 1) << 29) | (32'(rvfi_trap) << 28) | (32'(rvfi_intr) << 27)
        | (32'(rvfi_mode) << 25) | (32'(rvfi_rd_addr) << 20) | (32'(rvfi_halt) << 19)
        | (32'(m_ovf) << 18) | (32'(rvfi_mem_wmask) << 14) | (32'(rvfi_mem_rmask) << 10)
        | (32'(rvfi_order) & 32'h3FF);
    b.push_back(hdr);
    b.push_back(rvfi_pc_rdata);
    b.push_back(rvfi_insn);
    if (rvfi_rd_addr != 5'd0) b.push_back(rvfi_rd_wdata);
    if (mem) begin
      b.push_back(rvfi_mem_addr);
      b.push_back((rvfi_mem_wmask != 4'h0) ? rvfi_mem_wdata : rvfi_mem_rdata);
    end
    for (int i = 0; i < b.size(); i++) m_beats.push_back({(i == b.size() - 1), b[i]});
    m_ovf = 1'b0;
    m_level++;
  endtask

  // Apply current inputs across one rising edge, then compare at the falling edge.
  task automatic tick();
    bit          hs, was_rst;
    int unsigned pre;
    was_rst = !rst_ni;
    if (!rst_ni) begin
      m_beats.delete();
      m_level = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
    end else begin
      pre = m_level;
      hs  = (m_level != 0) && trace_ready_i;
      if (hs) begin
        if (m_beats[0][32]) m_level--;
        void'(m_beats.pop_front());
      end
      if (trace_en_i && rvfi_valid) begin
        if (pre == Depth) begin
          m_ovf = 1'b1;
          if (m_drop != 32'hFFFF) m_drop++;
        end else begin
          model_push();
        end
      end
    end
    @(negedge clk);
    chk("level", 64'(fifo_level_o), 64'(m_level));
    chk("drop",  64'(drop_cnt_o),   64'(m_drop));
    chk("valid", 64'(trace_valid_o), 64'(m_level != 0));
    if (m_level != 0) begin
      chk("data", 64'(trace_data_o), 64'(m_beats[0][31:0]));
      chk("last", 64'(trace_last_o), 64'(m_beats[0][32]));
    end else if (was_rst) begin
      chk("rst_data", 64'(trace_data_o), 64'h0);
      chk("rst_last", 64'(trace_last_o), 64'h0);
    end
  endtask

  task automatic rand_rec();
    rvfi_order     = {$urandom, $urandom};
    rvfi_insn      = $urandom;
    rvfi_pc_rdata  = $urandom;
    rvfi_rd_wdata  = $urandom;
    rvfi_trap      = 1'($urandom);
    rvfi_halt      = 1'($urandom);
    rvfi_intr      = 1'($urandom);
    rvfi_mode      = 2'($urandom);
    rvfi_rd_addr   = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rvfi_mem_addr  = $urandom;
    rvfi_mem_rdata = $urandom;
    rvfi_mem_wdata = $urandom;
    rvfi_mem_rmask = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
    rvfi_mem_wmask = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
  endtask

  task automatic quiet_rec();
    rand_rec();
    rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_intr = 1'b0;
    rvfi_rd_addr = 5'd0; rvfi_mem_rmask = 4'h0; rvfi_mem_wmask = 4'h0;
  endtask

  task automatic idle_ticks(input int unsigned n);
    rvfi_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_ni = 1'b0; trace_en_i = 1'b0; rvfi_valid = 1'b0; trace_ready_i = 1'b0;
    quiet_rec();
    tick();
    rst_ni = 1'b1;
    trace_en_i = 1'b1;
    trace_ready_i = 1'b1;

    // Single retirement, rd=0: three beats.
    quiet_rec();
    rvfi_order = 64'd0; rvfi_pc_rdata = 32'h100; rvfi_insn = 32'h13; rvfi_valid = 1'b1;
    tick();
    chk("single_cnt", 64'(trace_data_o[31:29]), 64'd2);
    idle_ticks(4);

    // Register write: four beats.
    quiet_rec();
    rvfi_order = 64'd1; rvfi_rd_addr = 5'd5; rvfi_rd_wdata = 32'hDEADBEEF; rvfi_valid = 1'b1;
    tick();
    chk("rd_hdr", 64'(trace_data_o[24:20]), 64'd5);
    idle_ticks(5);

    // Store.
    quiet_rec();
    rvfi_order = 64'd2; rvfi_mem_wmask = 4'hF; rvfi_mem_addr = 32'h2000;
    rvfi_mem_wdata = 32'h1234; rvfi_valid = 1'b1;
    tick();
    chk("st_wmask", 64'(trace_data_o[17:14]), 64'hF);
    idle_ticks(6);

    // Overflow with sink stalled.
    trace_ready_i = 1'b0;
    for (int unsigned i = 0; i < Depth + 3; i++) begin
      rand_rec();
      rvfi_order = 64'(i);
      rvfi_valid = 1'b1;
      tick();
    end
    idle_ticks(1);
    chk("ovf_level", 64'(fifo_level_o), 64'(Depth));
    chk("ovf_drop",  64'(drop_cnt_o), 64'd3);
    trace_ready_i = 1'b1;
    idle_ticks(Depth * 6 + 2);
    rand_rec(); rvfi_valid = 1'b1;
    tick();
    chk("ovf_set", 64'(trace_data_o[18]), 64'd1);
    idle_ticks(6);
    rand_rec(); rvfi_valid = 1'b1;
    tick();
    chk("ovf_clr", 64'(trace_data_o[18]), 64'd0);
    idle_ticks(6);

    // Backpressure: ready alternates, order steps per packet.
    for (int unsigned i = 0; i < 48; i++) begin
      trace_ready_i = i[0];
      rand_rec();
      rvfi_order = 64'(100 + i);
      rvfi_valid = (i % 6 == 0);
      tick();
    end
    trace_ready_i = 1'b1;
    idle_ticks(Depth * 6 + 2);

    // Reset after beat 1 has been accepted.
    rand_rec(); rvfi_valid = 1'b1;
    tick();
    idle_ticks(2);
    rst_ni = 1'b0;
    tick();
    chk("rst_level", 64'(fifo_level_o), 64'd0);
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    rst_ni = 1'b1;

    // Random traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      rand_rec();
      trace_en_i    = ($urandom % 8 != 0);
      rvfi_valid    = 1'($urandom);
      trace_ready_i = ($urandom % 10 < 7);
      rst_ni        = ($urandom % 500 != 0);
      tick();
    end
    rst_ni = 1'b1;
    trace_en_i = 1'b1;
    trace_ready_i = 1'b1;
    idle_ticks(Depth * 6 + 4);
    chk("final_level", 64'(fifo_level_o), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
